// File: rtl/rv32i_pkg.sv
// Shared register-file constants for the RV32I integer datapath.
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // x0 is hardwired to zero: it is never written and never tracked as busy.
    function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] r);
        return r != REG_ZERO;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer just past the winner when the grant is consumed.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [PW-1:0] gnt_idx;
    logic          found;

    // Cyclic priority search starting at the pointer.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr_reg) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Pointer successor: one past the granted index, wrapping at N.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
        ptr_next = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end

    // Pointer only moves when the grant was actually taken.
    always_ff @(posedge clk) begin
        if (reset)        ptr_reg <= '0;
        else if (advance) ptr_reg <= ptr_next;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback sequencer: round-robin over writeback sources onto
// the single write port, plus a busy scoreboard that stalls hazardous issue.
module rf_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      wb_valid,
    input  logic [NUM_REQ*5-1:0]    wb_rd,
    input  logic [NUM_REQ*XLEN-1:0] wb_data,
    output logic [NUM_REQ-1:0]      wb_ready,
    input  logic                    iss_valid,
    input  logic [4:0]              iss_rs1,
    input  logic                    iss_rs1_en,
    input  logic [4:0]              iss_rs2,
    input  logic                    iss_rs2_en,
    input  logic [4:0]              iss_rd,
    input  logic                    iss_rd_en,
    output logic                    iss_stall,
    output logic [4:0]              rd,
    output logic                    rd_en,
    output logic [XLEN-1:0]         rd_data,
    output logic [31:0]             busy_vec
);

    logic [NUM_REQ-1:0] gnt;
    logic               transfer;
    logic [4:0]         masked_rd   [NUM_REQ];
    logic [XLEN-1:0]    masked_data [NUM_REQ];
    logic [4:0]         sel_rd;
    logic [XLEN-1:0]    sel_data;

    logic [4:0]         rd_reg;
    logic               rd_en_reg;
    logic [XLEN-1:0]    rd_data_reg;
    logic [31:0]        busy_reg;
    logic [31:0]        busy_next;
    logic               issue_sets;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (wb_valid),
        .advance (transfer),
        .gnt     (gnt)
    );

    // Grants are suppressed during reset so no transfer can slip through.
    assign wb_ready = reset ? '0 : gnt;
    assign transfer = |wb_ready;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked_rd[gi]   = wb_ready[gi] ? wb_rd[gi*5 +: 5]         : '0;
            assign masked_data[gi] = wb_ready[gi] ? wb_data[gi*XLEN +: XLEN] : '0;
        end
    endgenerate

    // One-hot grant makes an OR-reduction a clean mux.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_rd   = sel_rd   | masked_rd[i];
            sel_data = sel_data | masked_data[i];
        end
    end

    // Registered write port: a transfer shows up on rd/rd_data one cycle later;
    // writes aimed at x0 are swallowed by keeping rd_en low.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_reg      <= '0;
            rd_en_reg   <= 1'b0;
            rd_data_reg <= '0;
        end else if (transfer) begin
            rd_reg      <= sel_rd;
            rd_en_reg   <= is_real_reg(sel_rd);
            rd_data_reg <= sel_data;
        end else begin
            rd_en_reg   <= 1'b0;
        end
    end

    // Hazard check against the scoreboard; no bypass from the write port.
    always_comb begin
        iss_stall = iss_valid & (
              (iss_rs1_en & is_real_reg(iss_rs1) & busy_reg[iss_rs1])
            | (iss_rs2_en & is_real_reg(iss_rs2) & busy_reg[iss_rs2])
            | (iss_rd_en  & is_real_reg(iss_rd)  & busy_reg[iss_rd]));
    end

    assign issue_sets = iss_valid & ~iss_stall & iss_rd_en & is_real_reg(iss_rd);

    // Clear on the write edge first, then apply the set so a same-edge set wins.
    always_comb begin
        busy_next = busy_reg;
        if (rd_en_reg) busy_next[rd_reg] = 1'b0;
        if (issue_sets) busy_next[iss_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk) begin
        if (reset) busy_reg <= '0;
        else       busy_reg <= busy_next;
    end

    assign rd       = rd_reg;
    assign rd_en    = rd_en_reg;
    assign rd_data  = rd_data_reg;
    assign busy_vec = busy_reg;

endmodule
